buffered_ram_arbiter: RTL and testbench
=======================================

Name: buffered_ram_arbiter

Overview:
Shares one simple-dual-port buffered RAM (1 write port, 1 registered read port, 2-cycle read latency, old-data on mixed read/write) between p_nreq requesters, e.g. USB command path and MIPI sequencer.
- Write port and read port are arbitrated independently, each round-robin.
- Read data is returned to the issuing requester with a one-hot valid.
- Sits between the requesters and the RAM instance.
- Drives the RAM's write enable, write address, write data and read address.

Parameters:
p_addresswidth, 4, RAM address bits
p_datawidth, 16, RAM data bits
p_nreq, 2, number of requesters; legal range 2..8

Ports:
inclk  in  1  system clock
inrst_n  in  1  asynchronous active-low reset
in_wrreq  in  p_nreq  per-requester write request
in_wraddress  in  p_nreq*p_addresswidth  write addresses; requester i at slice [i*AW +: AW]
in_wrdata  in  p_nreq*p_datawidth  write data, sliced as above
out_wrack  out  p_nreq  one-hot write grant; combinational
in_rdreq  in  p_nreq  per-requester read request
in_rdaddress  in  p_nreq*p_addresswidth  read addresses, sliced
out_rdack  out  p_nreq  one-hot read grant; combinational
out_rddata  out  p_datawidth  returned read data, shared by all requesters
out_rdvalid  out  p_nreq  one-hot; marks out_rddata as valid for requester i
out_rdpending  out  2  count of reads in flight (0..3)
out_ram_wren  out  1  to RAM write enable
out_ram_wraddress  out  p_addresswidth  to RAM write address
out_ram_wrdata  out  p_datawidth  to RAM write data
out_ram_rdaddress  out  p_addresswidth  to RAM read address
in_ram_rddata  in  p_datawidth  from RAM read data

Behaviour:
- Reset: single clock inclk; reset is asynchronous and active-low (inrst_n). Values while inrst_n=0:
  - out_ram_wren=0, out_ram_wraddress=0, out_ram_wrdata=0, out_ram_rdaddress=0
  - out_rdvalid=0, out_rdpending=0
  - both round-robin pointers=0
  - out_wrack/out_rdack=0
- Handshake: a transfer occurs in any cycle where in_xxreq[i]=1 and out_xxack[i]=1.
  - The requester holds req, address and data stable until acked.
  - If the requester deasserts req before ack, the request is withdrawn; no transfer.
  - At most one write ack and one read ack per cycle. Back-to-back acks to the same requester are allowed.
- Arbitration: per port, round-robin.
  - Search order starts at (last granted + 1) mod p_nreq.
  - Pointer updates only on a transfer.
  - After reset, requester 0 has highest priority.
- Write path: a write acked in cycle T is registered and presented on out_ram_* in T+1 with out_ram_wren=1 for exactly one cycle. The RAM is written at the end of T+1.
- Read path: read acked in T.
  - out_ram_rdaddress is registered and valid in T+1.
  - The RAM registers the address at the end of T+1 and the output at the end of T+2.
  - out_rdvalid[i]=1 in T+3, with out_rddata=in_ram_rddata.
  - Fixed latency of 3 cycles, tracked by a 3-stage one-hot valid shift register.
- out_rdpending counts acked reads not yet returned.
  - +1 on read ack, -1 on out_rdvalid; both in the same cycle gives no change.
  - Never exceeds 3.
- Read-during-write: a write and a read to the same address acked in the same cycle T return the OLD data. A read acked at T+1 or later returns the new data.
- The write and read ports are independent: simultaneous write and read acks to the same or different requesters are legal.
- Reset asserted mid-operation:
  - In-flight reads are dropped; no out_rdvalid after release.
  - A pending write registered but not yet presented is lost.
  - RAM contents are not cleared.
- No requests: all acks stay 0, out_ram_wren=0, and out_ram_rdaddress holds its last value.

Optional Feature:
BUFFERED_RAM_ARB_RAWFWD_EN
- Defined: read-after-write forwarding.
  - If a read is acked in cycle T with the same address as a write acked in T, the write data is carried down a 3-stage data pipeline.
  - out_rddata in T+3 is the forwarded write data instead of in_ram_rddata.
- Undefined: the forwarding pipeline is absent and OLD_DATA behaviour applies as above.

Decomposition:
- Shared include/package holds:
  - C_RD_LATENCY=3
  - pointer/one-hot width helpers
  - a clog2 function
- Sub-module rr_arbiter (parameter p_nreq; ports: req, advance, grant one-hot), instantiated twice: write port and read port.
- The top level holds the RAM-side registers, the read return pipeline, the out_rdpending counter and the optional forwarding logic.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles; out_rdpending=0.
- Write conflict: req0 and req1 both write continuously (addr 3/5, data 0xAAAA/0x5555).
  - Acks alternate 0,1,0,1 starting with 0.
  - out_ram_wren=1 every cycle; RAM ends with [3]=0xAAAA, [5]=0x5555.
- Read latency: after the writes above, req1 reads addr 5, acked in cycle T.
  - out_rdvalid=2'b10 and out_rddata=0x5555 exactly in T+3.
  - out_rdpending=1 during T+1..T+3, returning to 0 in T+4.
- Same-cycle collision: write 0x1234 to addr 7 (old value 0x0000) and read addr 7 acked in the same cycle.
  - Without the macro: returns 0x0000.
  - With BUFFERED_RAM_ARB_RAWFWD_EN: returns 0x1234.
  - A read acked one cycle later returns 0x1234 in both builds.
- Reset mid-read: 3 reads in flight, inrst_n pulsed low for 1 cycle.
  - No out_rdvalid afterwards; out_rdpending=0.
  - Next read arbitration starts at requester 0.
- Withdrawn request: req1 raises in_rdreq for 1 cycle while req0 is granted, then drops it.
  - No ack to req1; no spurious out_rdvalid[1].

Source files
------------

// File: rtl/buffered_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : buffered_ram_arbiter_pkg
// Description : Shared constants and width helpers for the buffered RAM
//               arbiter and its round-robin sub-arbiter.
//               - C_RD_LATENCY : cycles from read ack to returned data
//               - C_PEND_W     : width of the in-flight read counter
//               - f_clog2      : ceiling log2 (constant evaluation)
//               - f_ptr_width  : width of a round-robin pointer for n ports
//               - f_count_width: width of a counter holding 0..max
// Revision    : 1.0 - initial release
// ============================================================================
package buffered_ram_arbiter_pkg;

    // Ack cycle -> registered RAM address -> RAM address reg -> RAM data reg.
    localparam int C_RD_LATENCY = 3;

    function automatic int f_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A pointer always needs at least one bit, even for a single port.
    function automatic int f_ptr_width(input int n);
        return (n <= 2) ? 1 : f_clog2(n);
    endfunction

    function automatic int f_count_width(input int max_value);
        return (max_value <= 1) ? 1 : f_clog2(max_value + 1);
    endfunction

    localparam int C_PEND_W = f_count_width(C_RD_LATENCY);

endpackage
`default_nettype wire

// File: rtl/buffered_ram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : buffered_ram_arbiter_rr_arbiter
// Description : Round-robin arbiter with a one-hot combinational grant.
//               The priority pointer names the requester searched first;
//               it resets to 0 and moves to (granted + 1) mod p_nreq only
//               when i_advance reports a completed transfer.
// Ports       : i_clk      - clock
//               i_rst_n    - asynchronous active-low reset
//               i_req      - request vector
//               i_advance  - a transfer occurred this cycle
//               o_grant    - one-hot grant (zero while in reset)
// Revision    : 1.0 - initial release
// ============================================================================
module buffered_ram_arbiter_rr_arbiter
    import buffered_ram_arbiter_pkg::*;
#(
    parameter int p_nreq = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [p_nreq-1:0] i_req,
    input  logic              i_advance,
    output logic [p_nreq-1:0] o_grant
);

    localparam int                 c_ptr_w = f_ptr_width(p_nreq);
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(p_nreq - 1);

    logic [c_ptr_w-1:0]  r_ptr;
    logic [2*p_nreq-1:0] w_req_dbl;
    logic [p_nreq-1:0]   w_rot;
    logic [p_nreq-1:0]   w_pick;
    logic [p_nreq-1:0]   w_grant;
    logic [c_ptr_w-1:0]  w_gidx;
    logic [c_ptr_w-1:0]  w_ptr_next;

    // Rotate the requests so the pointer position lands on bit 0, take the
    // lowest set bit, then rotate the single hot bit back. Doubling the
    // vector turns both rotations into plain shifts.
    assign w_req_dbl = {i_req, i_req};
    assign w_rot     = p_nreq'(w_req_dbl >> r_ptr);
    assign w_pick    = w_rot & (-w_rot);
    assign w_grant   = p_nreq'(({w_pick, w_pick} << r_ptr) >> p_nreq);

    assign o_grant   = i_rst_n ? w_grant : '0;

    always_comb begin
        w_gidx = '0;
        for (int k = 0; k < p_nreq; k++) begin
            if (w_grant[k]) begin
                w_gidx = c_ptr_w'(k);
            end
        end
    end

    assign w_ptr_next = (w_gidx == c_last) ? '0 : (w_gidx + c_ptr_w'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/buffered_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : buffered_ram_arbiter
// Description : Shares one simple-dual-port RAM (registered read, 2-cycle
//               read latency, old data on a same-edge read/write) between
//               p_nreq requesters. Write and read ports are arbitrated
//               independently, each round-robin. Read data returns three
//               cycles after the ack with a one-hot valid naming the issuer.
// Option      : BUFFERED_RAM_ARB_RAWFWD_EN - when defined, a read acked in
//               the same cycle as a write to the same address returns the
//               write data instead of the RAM's old data.
// Ports       : inclk / inrst_n           - clock, async active-low reset
//               in_wrreq/in_wraddress/in_wrdata, out_wrack - write port
//               in_rdreq/in_rdaddress, out_rdack            - read port
//               out_rddata, out_rdvalid   - returned data, one-hot owner
//               out_rdpending             - reads in flight (0..3)
//               out_ram_wren/out_ram_wraddress/out_ram_wrdata,
//               out_ram_rdaddress, in_ram_rddata            - RAM side
// Revision    : 1.0 - initial release
// ============================================================================
module buffered_ram_arbiter
    import buffered_ram_arbiter_pkg::*;
#(
    parameter int p_addresswidth = 4,
    parameter int p_datawidth    = 16,
    parameter int p_nreq         = 2
) (
    input  logic                             inclk,
    input  logic                             inrst_n,
    input  logic [p_nreq-1:0]                in_wrreq,
    input  logic [p_nreq*p_addresswidth-1:0] in_wraddress,
    input  logic [p_nreq*p_datawidth-1:0]    in_wrdata,
    output logic [p_nreq-1:0]                out_wrack,
    input  logic [p_nreq-1:0]                in_rdreq,
    input  logic [p_nreq*p_addresswidth-1:0] in_rdaddress,
    output logic [p_nreq-1:0]                out_rdack,
    output logic [p_datawidth-1:0]           out_rddata,
    output logic [p_nreq-1:0]                out_rdvalid,
    output logic [C_PEND_W-1:0]              out_rdpending,
    output logic                             out_ram_wren,
    output logic [p_addresswidth-1:0]        out_ram_wraddress,
    output logic [p_datawidth-1:0]           out_ram_wrdata,
    output logic [p_addresswidth-1:0]        out_ram_rdaddress,
    input  logic [p_datawidth-1:0]           in_ram_rddata
);

    logic [p_nreq-1:0]         w_wrack;
    logic [p_nreq-1:0]         w_rdack;
    logic                      w_wr_xfer;
    logic                      w_rd_xfer;
    logic                      w_rd_ret;
    logic [p_addresswidth-1:0] w_wr_addr;
    logic [p_datawidth-1:0]    w_wr_data;
    logic [p_addresswidth-1:0] w_rd_addr;

    logic                      r_ram_wren;
    logic [p_addresswidth-1:0] r_ram_wraddr;
    logic [p_datawidth-1:0]    r_ram_wrdata;
    logic [p_addresswidth-1:0] r_ram_rdaddr;
    logic [p_nreq-1:0]         r_rd_vld [C_RD_LATENCY];
    logic [C_PEND_W-1:0]       r_rd_pending;

    // ------------------------------------------------------------------
    // Arbiters
    // ------------------------------------------------------------------
    buffered_ram_arbiter_rr_arbiter #(
        .p_nreq    (p_nreq)
    ) u_wr_arb (
        .i_clk     (inclk),
        .i_rst_n   (inrst_n),
        .i_req     (in_wrreq),
        .i_advance (w_wr_xfer),
        .o_grant   (w_wrack)
    );

    buffered_ram_arbiter_rr_arbiter #(
        .p_nreq    (p_nreq)
    ) u_rd_arb (
        .i_clk     (inclk),
        .i_rst_n   (inrst_n),
        .i_req     (in_rdreq),
        .i_advance (w_rd_xfer),
        .o_grant   (w_rdack)
    );

    assign out_wrack = w_wrack;
    assign out_rdack = w_rdack;
    assign w_wr_xfer = |(in_wrreq & w_wrack);
    assign w_rd_xfer = |(in_rdreq & w_rdack);

    // Grants are one-hot, so selecting by assignment picks exactly one slice.
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        w_rd_addr = '0;
        for (int i = 0; i < p_nreq; i++) begin
            if (w_wrack[i]) begin
                w_wr_addr = in_wraddress[i*p_addresswidth +: p_addresswidth];
                w_wr_data = in_wrdata[i*p_datawidth +: p_datawidth];
            end
            if (w_rdack[i]) begin
                w_rd_addr = in_rdaddress[i*p_addresswidth +: p_addresswidth];
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM-side registers
    // ------------------------------------------------------------------
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            r_ram_wren   <= 1'b0;
            r_ram_wraddr <= '0;
            r_ram_wrdata <= '0;
        end else begin
            r_ram_wren <= w_wr_xfer;
            if (w_wr_xfer) begin
                r_ram_wraddr <= w_wr_addr;
                r_ram_wrdata <= w_wr_data;
            end
        end
    end

    // The read address holds its last value while no read is granted.
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            r_ram_rdaddr <= '0;
        end else if (w_rd_xfer) begin
            r_ram_rdaddr <= w_rd_addr;
        end
    end

    assign out_ram_wren      = r_ram_wren;
    assign out_ram_wraddress = r_ram_wraddr;
    assign out_ram_wrdata    = r_ram_wrdata;
    assign out_ram_rdaddress = r_ram_rdaddr;

    // ------------------------------------------------------------------
    // Read return pipeline: the issuer's one-hot ack travels alongside the
    // RAM access and surfaces as out_rdvalid when the RAM data arrives.
    // ------------------------------------------------------------------
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            for (int s = 0; s < C_RD_LATENCY; s++) begin
                r_rd_vld[s] <= '0;
            end
        end else begin
            r_rd_vld[0] <= w_rd_xfer ? w_rdack : '0;
            for (int s = 1; s < C_RD_LATENCY; s++) begin
                r_rd_vld[s] <= r_rd_vld[s-1];
            end
        end
    end

    assign out_rdvalid = r_rd_vld[C_RD_LATENCY-1];
    assign w_rd_ret    = |r_rd_vld[C_RD_LATENCY-1];

    // Fixed latency bounds the count: at most one read per cycle can be in
    // each pipeline stage, so a new ack alongside a return keeps it at 3.
    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            r_rd_pending <= '0;
        end else begin
            case ({w_rd_xfer, w_rd_ret})
                2'b10:   r_rd_pending <= r_rd_pending + C_PEND_W'(1);
                2'b01:   r_rd_pending <= r_rd_pending - C_PEND_W'(1);
                default: r_rd_pending <= r_rd_pending;
            endcase
        end
    end

    assign out_rdpending = r_rd_pending;

    // ------------------------------------------------------------------
    // Optional same-cycle read-after-write forwarding
    // ------------------------------------------------------------------
`ifdef BUFFERED_RAM_ARB_RAWFWD_EN
    logic                   w_fwd_hit;
    logic                   r_fwd_vld  [C_RD_LATENCY];
    logic [p_datawidth-1:0] r_fwd_data [C_RD_LATENCY];

    // Only the same-cycle case needs help: a write acked one cycle earlier
    // already reaches the RAM array before the read samples it.
    assign w_fwd_hit = w_wr_xfer && w_rd_xfer && (w_wr_addr == w_rd_addr);

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            for (int s = 0; s < C_RD_LATENCY; s++) begin
                r_fwd_vld[s]  <= 1'b0;
                r_fwd_data[s] <= '0;
            end
        end else begin
            r_fwd_vld[0]  <= w_fwd_hit;
            r_fwd_data[0] <= w_wr_data;
            for (int s = 1; s < C_RD_LATENCY; s++) begin
                r_fwd_vld[s]  <= r_fwd_vld[s-1];
                r_fwd_data[s] <= r_fwd_data[s-1];
            end
        end
    end

    assign out_rddata = r_fwd_vld[C_RD_LATENCY-1] ? r_fwd_data[C_RD_LATENCY-1]
                                                  : in_ram_rddata;
`else
    assign out_rddata = in_ram_rddata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffered_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffered_ram_arbiter
// Description : Self-checking bench for buffered_ram_arbiter with a
//               behavioural RAM, a reference model of arbitration and
//               memory contents, and a scoreboard of expected read returns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffered_ram_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int N     = 2;
    localparam int DEPTH = 1 << AW;

    logic            inclk;
    logic            inrst_n;
    logic [N-1:0]    in_wrreq;
    logic [N*AW-1:0] in_wraddress;
    logic [N*DW-1:0] in_wrdata;
    logic [N-1:0]    out_wrack;
    logic [N-1:0]    in_rdreq;
    logic [N*AW-1:0] in_rdaddress;
    logic [N-1:0]    out_rdack;
    logic [DW-1:0]   out_rddata;
    logic [N-1:0]    out_rdvalid;
    logic [1:0]      out_rdpending;
    logic            out_ram_wren;
    logic [AW-1:0]   out_ram_wraddress;
    logic [DW-1:0]   out_ram_wrdata;
    logic [AW-1:0]   out_ram_rdaddress;
    logic [DW-1:0]   in_ram_rddata;

    buffered_ram_arbiter #(
        .p_addresswidth (AW),
        .p_datawidth    (DW),
        .p_nreq         (N)
    ) dut (
        .inclk             (inclk),
        .inrst_n           (inrst_n),
        .in_wrreq          (in_wrreq),
        .in_wraddress      (in_wraddress),
        .in_wrdata         (in_wrdata),
        .out_wrack         (out_wrack),
        .in_rdreq          (in_rdreq),
        .in_rdaddress      (in_rdaddress),
        .out_rdack         (out_rdack),
        .out_rddata        (out_rddata),
        .out_rdvalid       (out_rdvalid),
        .out_rdpending     (out_rdpending),
        .out_ram_wren      (out_ram_wren),
        .out_ram_wraddress (out_ram_wraddress),
        .out_ram_wrdata    (out_ram_wrdata),
        .out_ram_rdaddress (out_ram_rdaddress),
        .in_ram_rddata     (in_ram_rddata)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    // Behavioural RAM: read sampled on the address edge (old data when a
    // write hits the same edge), then an output register.
    logic [DW-1:0] ram [DEPTH] = '{default: '0};
    logic [DW-1:0] ram_q1 = '0;
    logic [DW-1:0] ram_q2 = '0;
    always @(posedge inclk) begin
        if (out_ram_wren) ram[out_ram_wraddress] <= out_ram_wrdata;
        ram_q1 <= ram[out_ram_rdaddress];
        ram_q2 <= ram_q1;
    end
    assign in_ram_rddata = ram_q2;

    int cyc = 0;
    always @(posedge inclk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    typedef struct {
        int            due;
        int            ack;
        int            req;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           exp_q[$];
    logic [DW-1:0] mdl_mem [DEPTH] = '{default: '0};
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    bit            pw_v = 1'b0;
    logic [AW-1:0] pw_a = '0;
    logic [DW-1:0] pw_d = '0;
    logic [AW-1:0] mdl_rdaddr = '0;
    int            wg = -1;
    int            rg = -1;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- stimulus state ----------------
    logic [N-1:0]  d_wrreq = '0;
    logic [N-1:0]  d_rdreq = '0;
    logic [AW-1:0] d_wa [N] = '{default: '0};
    logic [AW-1:0] d_ra [N] = '{default: '0};
    logic [DW-1:0] d_wd [N] = '{default: '0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic apply();
        in_wrreq = d_wrreq;
        in_rdreq = d_rdreq;
        for (int i = 0; i < N; i++) begin
            in_wraddress[i*AW +: AW] = d_wa[i];
            in_wrdata[i*DW +: DW]    = d_wd[i];
            in_rdaddress[i*AW +: AW] = d_ra[i];
        end
    endtask

    // Called at posedge+1: drive, check acks and RAM-side outputs mid-cycle,
    // advance the model, then move on to the next posedge+1.
    task automatic run_cycle();
        logic [DW-1:0] v;
        apply();
        #2;
        check("ram_wren", out_ram_wren, pw_v);
        if (pw_v) begin
            check("ram_wraddress", out_ram_wraddress, pw_a);
            check("ram_wrdata", out_ram_wrdata, pw_d);
            mdl_mem[pw_a] = pw_d;
            pw_v = 1'b0;
        end
        check("ram_rdaddress", out_ram_rdaddress, mdl_rdaddr);
        wg = rr_pick(d_wrreq, wr_ptr);
        rg = rr_pick(d_rdreq, rd_ptr);
        check("wrack", out_wrack, onehot(wg));
        check("rdack", out_rdack, onehot(rg));
        if (rg >= 0) begin
            v = mdl_mem[d_ra[rg]];
`ifdef BUFFERED_RAM_ARB_RAWFWD_EN
            if (wg >= 0 && d_wa[wg] == d_ra[rg]) v = d_wd[wg];
`endif
            exp_q.push_back('{due: cyc + 3, ack: cyc, req: rg, data: v});
            mdl_rdaddr = d_ra[rg];
            rd_ptr = (rg + 1) % N;
        end
        if (wg >= 0) begin
            pw_v   = 1'b1;
            pw_a   = d_wa[wg];
            pw_d   = d_wd[wg];
            wr_ptr = (wg + 1) % N;
        end
        @(posedge inclk);
        #1;
    endtask

    task automatic idle(input int n);
        d_wrreq = '0;
        d_rdreq = '0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // One-cycle reset pulse with requests asserted, which must not be acked.
    task automatic do_reset();
        inrst_n = 1'b0;
        d_wrreq = '1;
        d_rdreq = '1;
        apply();
        exp_q.delete();
        pw_v       = 1'b0;
        wr_ptr     = 0;
        rd_ptr     = 0;
        mdl_rdaddr = '0;
        wg         = -1;
        rg         = -1;
        #2;
        check("rst_wrack", out_wrack, '0);
        check("rst_rdack", out_rdack, '0);
        check("rst_ram_wren", out_ram_wren, 1'b0);
        check("rst_ram_wraddress", out_ram_wraddress, '0);
        check("rst_ram_wrdata", out_ram_wrdata, '0);
        check("rst_ram_rdaddress", out_ram_rdaddress, '0);
        @(posedge inclk);
        #1;
        inrst_n = 1'b1;
        d_wrreq = '0;
        d_rdreq = '0;
        apply();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [N-1:0] ev;
        int           pend;
        forever begin
            @(negedge inclk);
            ev   = '0;
            pend = 0;
            foreach (exp_q[k]) if (exp_q[k].ack < cyc) pend++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                ev = onehot(exp_q[0].req);
                check("rddata", out_rddata, exp_q[0].data);
            end
            check("rdvalid", out_rdvalid, ev);
            check("rdpending", out_rdpending, pend);
            if (ev != '0) void'(exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        inrst_n = 1'b0;
        apply();
        @(posedge inclk);
        #1;
        do_reset();

        // Idle after reset
        idle(10);

        // Write conflict: both requesters write continuously
        d_wa[0] = 4'd3; d_wd[0] = 16'hAAAA;
        d_wa[1] = 4'd5; d_wd[1] = 16'h5555;
        d_wrreq = 2'b11;
        for (int i = 0; i < 6; i++) run_cycle();
        idle(2);
        check("ram_addr3", ram[3], 16'hAAAA);
        check("ram_addr5", ram[5], 16'h5555);

        // Read latency: requester 1 reads address 5
        d_ra[1] = 4'd5;
        d_rdreq = 2'b10;
        run_cycle();
        idle(5);

        // Same-cycle collision on address 7, then a read one cycle later
        d_wa[0] = 4'd7; d_wd[0] = 16'h1234; d_ra[0] = 4'd7;
        d_wrreq = 2'b01;
        d_rdreq = 2'b01;
        run_cycle();
        d_wrreq = 2'b00;
        d_ra[1] = 4'd7;
        d_rdreq = 2'b10;
        run_cycle();
        idle(5);

        // Reset with three reads in flight
        d_ra[0] = 4'd3; d_ra[1] = 4'd5;
        d_rdreq = 2'b11;
        for (int i = 0; i < 3; i++) run_cycle();
        do_reset();
        idle(5);
        d_rdreq = 2'b11;
        run_cycle();
        idle(4);

        // Withdrawn request from requester 1 while requester 0 is granted
        d_rdreq = 2'b10;
        run_cycle();
        d_rdreq = 2'b11;
        run_cycle();
        d_rdreq = 2'b01;
        run_cycle();
        idle(5);

        // Randomised traffic with hold-until-ack, withdrawals and resets
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                if (d_wrreq[i] && wg != i) begin
                    if ($urandom_range(0, 15) == 0) d_wrreq[i] = 1'b0;
                end else begin
                    d_wrreq[i] = 1'($urandom_range(0, 1));
                    d_wa[i]    = AW'($urandom_range(0, 3));
                    d_wd[i]    = DW'($urandom);
                end
                if (d_rdreq[i] && rg != i) begin
                    if ($urandom_range(0, 15) == 0) d_rdreq[i] = 1'b0;
                end else begin
                    d_rdreq[i] = 1'($urandom_range(0, 1));
                    d_ra[i]    = AW'($urandom_range(0, 3));
                end
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else run_cycle();
        end
        idle(6);
        check("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
